// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: controller state encoding and default operand width.
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_sub_cell.sv
// serial_sub_cell: 1-bit full subtractor from two half-subtractor stages and a borrow OR.
module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;
  assign d1 = a ^ b;
  assign b1 = ~a & b;
  assign d = d1 ^ bin;
  assign b2 = ~d1 & bin;
  assign bout = b1 | b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial A-B, LSB first, one subtractor cell reused over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_nxt;
  // Only the upper WIDTH-1 result bits need storing; the last bit goes straight to diff.
  logic [WIDTH-1:1] res;
  logic [CNT_W-1:0] cnt;
  logic br, d, br_nxt, last;
  serial_sub_cell u_cell (.a(a_sr[0]), .b(b_sr[0]), .bin(br), .d(d), .bout(br_nxt));
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign res_nxt = {d, res};
  assign ready = state == IDLE;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf <= 1'b0;
    end else if (ready && start) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (busy && last) ovf <= (a_msb ^ b_msb) & (a_msb ^ d);
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      res <= '0;
      cnt <= '0;
      br <= 1'b0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else if (ready && start) begin
      a_sr <= a;
      b_sr <= b;
      cnt <= '0;
      br <= 1'b0;
    end else if (busy) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      res <= res_nxt[WIDTH-1:1];
      br <= br_nxt;
      cnt <= last ? cnt : cnt + CNT_W'(1);
      if (last) begin
        diff <= res_nxt;
        borrow_out <= br_nxt;
      end
    end
  end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: randomized + directed scoreboard bench against an occupancy/arithmetic model.
module tb_serial_sub_ctrl;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] a = '0, b = '0, diff;
  logic ready, busy, done, borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
`endif
  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {logic [W-1:0] d; logic br; logic ov;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  // cycles left until the unit can accept again; an operation occupies WIDTH+2 cycles
  int rem = 0;
  logic [W-1:0] hd = '0;
  logic hb = 0, ho = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint r;
    r = longint'($signed(x)) - longint'($signed(y));
    e.d = W'(x - y);
    e.br = x < y;
    e.ov = (r < -(longint'(1) << (W - 1))) || (r > (longint'(1) << (W - 1)) - 1);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      rem = 0;
    end else if (rem == 0 && start) begin
      q.push_back(model(a, b));
      rem = W + 1;
    end else if (rem > 0) rem--;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hd = '0;
      hb = 0;
      ho = 0;
    end
    chk("ready", 32'(ready), 32'(rem == 0));
    chk("busy", 32'(busy), 32'(rem >= 2));
    chk("done", 32'(done), 32'(rem == 1));
    if (done) begin
      if (q.size() == 0) chk("spurious_done", 32'(done), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        hd = e.d;
        hb = e.br;
        ho = e.ov;
      end
    end
    chk("diff", 32'(diff), 32'(hd));
    chk("borrow_out", 32'(borrow_out), 32'(hb));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(ovf), 32'(ho));
`endif
  end

  task automatic wait_idle();
    int n = 0;
    while (rem != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rem != 0) chk("idle_timeout", 32'(rem), 32'd0);
  endtask

  task automatic go(input logic [W-1:0] x, input logic [W-1:0] y);
    wait_idle();
    a = x;
    b = y;
    start = 1;
    @(negedge clk);
    start = 0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((rem != 0 || q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    go(8'h5A, 8'h23);
    drain();
    go(8'h10, 8'h20);
    go(8'h00, 8'h01);
    go(8'hAA, 8'hAA);
    drain();
    go(8'h05, 8'h03);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1;
    @(negedge clk);
    start = 0;
    for (int n = 0; n < 20 && rem != 1; n++) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    drain();
    go(8'h40, 8'h01);
    repeat (3) @(negedge clk);
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    go(8'h03, 8'h01);
    drain();
    a = 8'h81; b = 8'h80; start = 1;
    repeat (30) @(negedge clk);
    start = 0;
    drain();
    go(8'h80, 8'h01);
    go(8'h7F, 8'hFF);
    go(8'h05, 8'h03);
    drain();
    for (int i = 0; i < 40; i++) begin
      go(W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, W)) @(negedge clk);
        a = W'($urandom); b = W'($urandom); start = 1;
        @(negedge clk);
        start = 0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
